hdmi_vtc_ctrl: RTL and testbench

Video timing controller that sequences the HDMI output path. It generates the `hsync`, `vsync` and active-area strobes consumed by the HDMI encoder/serializer top level. It also requests pixels from the upstream frame source one cycle ahead of need, and flags underflow when that source fails to deliver. It runs entirely in the pixel clock domain and sits between the pixel source (frame buffer / processing pipeline) and the HDMI top.

---
 rtl/hdmi_vtc_pkg.sv | 26 ++
 rtl/vtc_span_counter.sv | 47 ++++
 rtl/hdmi_vtc_ctrl.sv | 117 +++++++++++
 tb/tb_hdmi_vtc_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_vtc_pkg.sv
// hdmi_vtc_pkg: shared state enum, counter width and video timing presets
package hdmi_vtc_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} vtc_state_e;

    localparam int VTC_CW = 12;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int HD_H_ACTIVE  = 1280;
    localparam int HD_H_FP      = 110;
    localparam int HD_H_SYNC    = 40;
    localparam int HD_H_BP      = 220;
    localparam int HD_V_ACTIVE  = 720;
    localparam int HD_V_FP      = 5;
    localparam int HD_V_SYNC    = 5;
    localparam int HD_V_BP      = 20;

endpackage

// File: rtl/vtc_span_counter.sv
// vtc_span_counter: wrapping span counter with terminal count and active/sync window decode
module vtc_span_counter
    import hdmi_vtc_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [VTC_CW-1:0] cnt_o,
    output logic              tc_o,
    output logic              act_o,
    output logic              sync_o,
    output logic              nxt_act_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    if (TOTAL > 4096 || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
        $error("vtc_span_counter: span fields must be nonzero and total at most 4096");
    end

    localparam logic [VTC_CW-1:0] LAST = VTC_CW'(TOTAL - 1);
    localparam logic [VTC_CW-1:0] A_END = VTC_CW'(ACTIVE);
    localparam logic [VTC_CW-1:0] S_BEG = VTC_CW'(ACTIVE + FP);
    localparam logic [VTC_CW-1:0] S_END = VTC_CW'(ACTIVE + FP + SYNC);

    logic [VTC_CW-1:0] cnt_q, cnt_d;

    assign tc_o      = cnt_q == LAST;
    assign cnt_d     = clr_i ? '0 : adv_i ? (tc_o ? '0 : cnt_q + VTC_CW'(1)) : cnt_q;
    assign cnt_o     = cnt_q;
    assign act_o     = cnt_q < A_END;
    assign sync_o    = cnt_q >= S_BEG && cnt_q < S_END;
    assign nxt_act_o = cnt_d < A_END;

    // span position register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hdmi_vtc_ctrl.sv
// hdmi_vtc_ctrl: HDMI video timing controller; HDMI_VTC_UNDERFLOW_EN enables underflow detection.
// The span counters run one pixel ahead of o_x/o_y so every strobe can be registered,
// and their next-value decode gives the pixel-request lookahead.
module hdmi_vtc_ctrl
    import hdmi_vtc_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              i_p_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_pix_valid,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_active_area,
    output logic              o_pix_req,
    output logic [VTC_CW-1:0] o_x,
    output logic [VTC_CW-1:0] o_y,
    output logic              o_frame_start,
    output logic              o_busy,
    output logic              o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    vtc_state_e        state_q, state_d;
    logic [VTC_CW-1:0] h_cnt, v_cnt, x_q, y_q;
    logic              h_tc, v_tc, h_act, v_act, h_sync, v_sync, h_nact, v_nact;
    logic              running_d, last_px;
    logic              hs_q, vs_q, act_q, req_q, fs_q, busy_q;

    assign last_px   = x_q == VTC_CW'(H_TOTAL - 1) && y_q == VTC_CW'(V_TOTAL - 1);
    assign running_d = state_d == RUN || state_d == DRAIN;

    // next state: PRIME is a single fixed cycle, DRAIN ignores enable until the frame ends
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_enable ? PRIME : IDLE;
            PRIME:   state_d = RUN;
            RUN:     state_d = i_enable ? RUN : DRAIN;
            default: state_d = last_px ? IDLE : DRAIN;
        endcase
    end

    vtc_span_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk_i(i_p_clk), .rst_i(i_reset), .clr_i(!running_d), .adv_i(running_d),
        .cnt_o(h_cnt), .tc_o(h_tc), .act_o(h_act), .sync_o(h_sync), .nxt_act_o(h_nact)
    );

    vtc_span_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk_i(i_p_clk), .rst_i(i_reset), .clr_i(!running_d), .adv_i(running_d && h_tc),
        .cnt_o(v_cnt), .tc_o(v_tc), .act_o(v_act), .sync_o(v_sync), .nxt_act_o(v_nact)
    );

    // state and registered strobes; a DRAIN wrap to (0,0) must not request the next frame
    always_ff @(posedge i_p_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            act_q   <= 1'b0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= running_d ? h_cnt : '0;
            y_q     <= running_d ? v_cnt : '0;
            hs_q    <= (running_d && h_sync) ? HSYNC_POL : ~HSYNC_POL;
            vs_q    <= (running_d && v_sync) ? VSYNC_POL : ~VSYNC_POL;
            act_q   <= running_d && h_act && v_act;
            req_q   <= state_d != IDLE && h_nact && v_nact && !(state_d == DRAIN && h_tc && v_tc);
            fs_q    <= running_d && h_cnt == '0 && v_cnt == '0;
            busy_q  <= state_d != IDLE;
        end
    end

`ifdef HDMI_VTC_UNDERFLOW_EN
    logic und_q;

    // sticky underflow, cleared when a new run starts
    always_ff @(posedge i_p_clk or posedge i_reset) begin
        if (i_reset) und_q <= 1'b0;
        else         und_q <= (state_q == IDLE && state_d == PRIME) ? 1'b0 : (und_q || (act_q && !i_pix_valid));
    end

    assign o_underflow = und_q;
`else
    logic unused_pix_valid;

    assign unused_pix_valid = i_pix_valid;
    assign o_underflow      = 1'b0;
`endif

    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_active_area = act_q;
    assign o_pix_req     = req_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_frame_start = fs_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_hdmi_vtc_ctrl.sv
// tb_hdmi_vtc_ctrl: scoreboard bench for hdmi_vtc_ctrl on an 8x6 total timing
module tb_hdmi_vtc_ctrl;

    localparam int NEVER = 1 << 30;
`ifdef HDMI_VTC_UNDERFLOW_EN
    localparam bit UND_ON = 1'b1;
`else
    localparam bit UND_ON = 1'b0;
`endif

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, pv;
    logic        hs, vs, act, req, fs, busy, und;
    logic [11:0] x, y;

    exp_t  q[$];
    exp_t  e;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    got;
    string names[9] = '{"hsync", "vsync", "active", "pix_req", "x", "y", "frame_start", "busy", "underflow"};

    hdmi_vtc_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .i_p_clk(clk), .i_reset(rst), .i_enable(en), .i_pix_valid(pv),
        .o_hsync(hs), .o_vsync(vs), .o_active_area(act), .o_pix_req(req),
        .o_x(x), .o_y(y), .o_frame_start(fs), .o_busy(busy), .o_underflow(und)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get(int sig);
        case (sig)
            0:       return int'(hs);
            1:       return int'(vs);
            2:       return int'(act);
            3:       return int'(req);
            4:       return int'(x);
            5:       return int'(y);
            6:       return int'(fs);
            7:       return int'(busy);
            default: return int'(und);
        endcase
    endfunction

    function automatic bit pact(int n);
        int px = n % 8;
        int py = (n / 8) % 6;
        return px < 4 && py < 3;
    endfunction

    task automatic push(int c, int sig, int val);
        exp_t t;
        t.cyc = c;
        t.sig = sig;
        t.val = val;
        q.push_back(t);
    endtask

    task automatic push_all(int c, int h, int v, int a, int r, int px, int py, int f, int b, int u);
        push(c, 0, h); push(c, 1, v); push(c, 2, a); push(c, 3, r); push(c, 4, px);
        push(c, 5, py); push(c, 6, f); push(c, 7, b); push(c, 8, u);
    endtask

    task automatic push_reset(int c);
        push_all(c, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_run(int s, int p, int last_m, int und_from);
        for (int m = 0; m <= last_m; m++) begin
            int c = s + 1 + m;
            int n = m - 1;
            int u = (UND_ON && c >= und_from) ? 1 : 0;
            int r = (m < p && pact(m)) ? 1 : 0;
            if (m >= 1 && m <= p)
                push_all(c, (n % 8 == 5 || n % 8 == 6) ? 0 : 1, ((n / 8) % 6 == 4) ? 0 : 1,
                         int'(pact(n)), r, n % 8, (n / 8) % 6, (n % 48 == 0) ? 1 : 0, 1, u);
            else
                push_all(c, 1, 1, 0, r, 0, 0, 0, (m == 0) ? 1 : 0, u);
        end
    endtask

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string nm, int g, int v);
        n_vec++;
        if (g != v) begin
            n_err++;
            $display("FAIL %s async reset: got %0d expected %0d", nm, g, v);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            got = get(e.sig);
            n_vec++;
            if (e.cyc != cyc || got != e.val) begin
                n_err++;
                $display("FAIL %s cyc=%0d (due %0d): got %0d expected %0d", names[e.sig], cyc, e.cyc, got, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s, s2, s3, s4;
        rst = 1'b1;
        en  = 1'b0;
        pv  = 1'b1;
        push_reset(2);
        goto(3);
        rst = 1'b0;
        s = 5;
        goto(s);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy high before enable");
        end
        push_run(s, 144, 146, NEVER);
        en = 1'b1;
        goto(s + 2 + 106);
        en = 1'b0;
        goto(s + 2 + 120);
        en = 1'b1;
        goto(s + 2 + 125);
        en = 1'b0;
        s2 = s + 150;
        goto(s2);
        push_run(s2, 48, 50, s2 + 4);
        en = 1'b1;
        goto(s2 + 3);
        pv = 1'b0;
        goto(s2 + 4);
        pv = 1'b1;
        goto(s2 + 2 + 20);
        en = 1'b0;
        s3 = s2 + 55;
        goto(s3);
        push_run(s3, 96, 26, NEVER);
        push_reset(s3 + 28);
        push_reset(s3 + 29);
        en = 1'b1;
        goto(s3 + 28);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("busy", int'(busy), 0);
        chk("active", int'(act), 0);
        chk("pix_req", int'(req), 0);
        chk("x", int'(x), 0);
        chk("y", int'(y), 0);
        chk("hsync", int'(hs), 1);
        chk("vsync", int'(vs), 1);
        chk("frame_start", int'(fs), 0);
        goto(s3 + 30);
        rst = 1'b0;
        s4 = s3 + 32;
        goto(s4);
        push_run(s4, 96, 50, NEVER);
        en = 1'b1;
        goto(s4 + 1);
        en = 1'b0;
        goto(s4 + 2);
        en = 1'b1;
        goto(s4 + 52);
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s due %0d: never checked, expected %0d", names[e.sig], e.cyc, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
